drop_scheduler: RTL

//  Game-play stage directly downstream of the LFSR drop-trigger generator. Samples

---
 rtl/drop_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/drop_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | drop_scheduler: spawns, advances and resolves falling objects per lane.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module drop_scheduler #(
  parameter int NUM_LANES = 8,
  parameter int ROWS      = 16,
  parameter int SPAWN_GAP = 2,
  parameter int MAX_MISS  = 5,
  localparam int LANE_W   = $clog2(NUM_LANES),
  localparam int ROW_W    = $clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       step_tick,
  input  logic [1:0]                 level,
  input  logic                       easy_t,
  input  logic                       normal_t,
  input  logic                       extreme_t,
  input  logic [LANE_W-1:0]          player_lane,
  output logic [NUM_LANES-1:0]       obj_valid,
  output logic [NUM_LANES*ROW_W-1:0] obj_row,
  output logic                       hit,
  output logic                       miss,
  output logic [7:0]                 score,
  output logic [3:0]                 miss_cnt,
  output logic                       running,
  output logic                       game_over
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_OVER = 2'd2;

  localparam int c_CD_W  = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;
  localparam int c_SUM_W = ((LANE_W + 1) > 4 ? (LANE_W + 1) : 4) + 1;

  logic [1:0]                       state_q, state_d;
  logic [LANE_W-1:0]                lane_ptr_q, lane_ptr_d;
  logic [NUM_LANES-1:0]             valid_q, valid_d;
  logic [NUM_LANES-1:0][ROW_W-1:0]  row_q, row_d;
  logic                             hit_q, hit_d;
  logic                             miss_q, miss_d;
  logic [7:0]                       score_q, score_d;
  logic [3:0]                       miss_cnt_q, miss_cnt_d;
  logic [c_CD_W-1:0]                cooldown_q, cooldown_d;

  logic [NUM_LANES-1:0]             w_land;
  logic [NUM_LANES-1:0]             w_kept;
  logic [NUM_LANES-1:0]             w_miss_mask;
  logic [LANE_W:0]                  w_miss_num;
  logic [c_SUM_W-1:0]               w_miss_sum;
  logic                             w_catch;
  logic                             w_trig;

  // Landing detection and miss accounting for the current step.
  always_comb begin
    w_land     = '0;
    w_miss_num = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_land[i] = valid_q[i] && (row_q[i] == ROW_W'(ROWS - 1));
    end
    w_kept      = valid_q & ~w_land;
    w_catch     = w_land[player_lane];
    w_miss_mask = w_land & ~(NUM_LANES'(1) << player_lane);
    for (int i = 0; i < NUM_LANES; i++) begin
      w_miss_num = w_miss_num + {{LANE_W{1'b0}}, w_miss_mask[i]};
    end
    w_miss_sum = c_SUM_W'(miss_cnt_q) + c_SUM_W'(w_miss_num);
    case (level)
      2'd0:    w_trig = easy_t;
      2'd1:    w_trig = normal_t;
      default: w_trig = extreme_t;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    lane_ptr_d = lane_ptr_q + LANE_W'(1);
    valid_d    = valid_q;
    row_d      = row_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;
    cooldown_d = cooldown_q;

    if (start) begin
      state_d    = c_RUN;
      valid_d    = '0;
      row_d      = '0;
      score_d    = '0;
      miss_cnt_d = '0;
      cooldown_d = '0;
    end else if (state_q == c_RUN && step_tick) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_land[i]) begin
          valid_d[i] = 1'b0;
          row_d[i]   = '0;
        end else if (valid_q[i]) begin
          row_d[i] = row_q[i] + ROW_W'(1);
        end
      end

      if (w_catch) begin
        hit_d   = 1'b1;
        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
      end

      if (w_miss_mask != '0) begin
        miss_d = 1'b1;
        if (w_miss_sum >= c_SUM_W'(MAX_MISS)) begin
          miss_cnt_d = 4'(MAX_MISS);
          state_d    = c_OVER;
        end else begin
          miss_cnt_d = w_miss_sum[3:0];
        end
      end

      // Lanes that landed this step count as empty for the spawn check.
      if (w_trig && cooldown_q == '0 && !w_kept[lane_ptr_q]) begin
        valid_d[lane_ptr_q] = 1'b1;
        row_d[lane_ptr_q]   = '0;
        cooldown_d          = c_CD_W'(SPAWN_GAP);
      end else if (cooldown_q != '0) begin
        cooldown_d = cooldown_q - c_CD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= c_IDLE;
      lane_ptr_q <= '0;
      valid_q    <= '0;
      row_q      <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      score_q    <= '0;
      miss_cnt_q <= '0;
      cooldown_q <= '0;
    end else begin
      state_q    <= state_d;
      lane_ptr_q <= lane_ptr_d;
      valid_q    <= valid_d;
      row_q      <= row_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
      cooldown_q <= cooldown_d;
    end
  end

  assign obj_valid = valid_q;
  assign obj_row   = row_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign miss_cnt  = miss_cnt_q;
  assign running   = (state_q == c_RUN);
  assign game_over = (state_q == c_OVER);

endmodule
`default_nettype wire
